// File: rtl/clmul16_kara_seq.sv
// rtl/clmul16_kara_seq.sv - 16x16 carry-less multiply sequencer over a shared 8x8 core
//
// Computes out_y = in_a * in_b over GF(2)[x] with three Karatsuba passes
// through one external 8x8 carry-less multiplier:
//   P0 = Al*Bl, P1 = (Ah^Al)*(Bh^Bl), P2 = Ah*Bh
//   y  = P2*x^16 ^ (P0^P1^P2)*x^8 ^ P0
// The cross term is folded into the accumulator pass by pass, so no product
// has to be stored beyond the running 31-bit accumulator.
//
// Parameters:
//   MUL_LAT   pipeline stages inside the external core (0..3); each pass
//             holds its operands for MUL_LAT+1 cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request operand pair valid
//   in_ready   block is idle and can accept operands
//   in_a       16-bit multiplicand, bit i = coefficient of x^i
//   in_b       16-bit multiplier
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_y      31-bit carry-less product
//   mul_a      registered operand A to the 8x8 core (0 when not in a pass)
//   mul_b      registered operand B to the 8x8 core (0 when not in a pass)
//   mul_y      15-bit product from the core, MUL_LAT cycles after operands

module clmul16_kara_seq #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] out_y,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [14:0] mul_y
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PASS_LO  = 3'd1;
  localparam logic [2:0] PASS_MID = 3'd2;
  localparam logic [2:0] PASS_HI  = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  // Wait count loaded at the start of every pass; the pass samples mul_y
  // when the count has run down to zero.
  localparam logic [1:0] CNT_INIT = 2'(MUL_LAT);

  logic [2:0]  state;
  logic [1:0]  cnt;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [30:0] acc;

  // Core product widened to accumulator width so the shifts below stay
  // inside 31 bits (largest term is P2<<16, top bit 30).
  logic [30:0] p_ext;
  assign p_ext = {16'd0, mul_y};

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      op_a      <= 16'd0;
      op_b      <= 16'd0;
      acc       <= 31'd0;
      out_y     <= 31'd0;
      out_valid <= 1'b0;
      mul_a     <= 8'd0;
      mul_b     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= in_a;
            op_b  <= in_b;
            acc   <= 31'd0;
            mul_a <= in_a[7:0];
            mul_b <= in_b[7:0];
            cnt   <= CNT_INIT;
            state <= PASS_LO;
          end
        end

        PASS_LO: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            // P0 contributes both at x^0 and, as part of the cross term, at x^8.
            acc   <= acc ^ p_ext ^ (p_ext << 8);
            mul_a <= op_a[15:8] ^ op_a[7:0];
            mul_b <= op_b[15:8] ^ op_b[7:0];
            cnt   <= CNT_INIT;
            state <= PASS_MID;
          end
        end

        PASS_MID: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            acc   <= acc ^ (p_ext << 8);
            mul_a <= op_a[15:8];
            mul_b <= op_b[15:8];
            cnt   <= CNT_INIT;
            state <= PASS_HI;
          end
        end

        PASS_HI: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            // P2 closes the cross term at x^8 and lands on its own at x^16.
            // The final sum goes straight to out_y rather than through acc.
            out_y     <= acc ^ (p_ext << 8) ^ (p_ext << 16);
            out_valid <= 1'b1;
            mul_a     <= 8'd0;
            mul_b     <= 8'd0;
            cnt       <= CNT_INIT;
            state     <= RESP;
          end
        end

        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          mul_a     <= 8'd0;
          mul_b     <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clmul16_kara_seq.sv
// tb/tb_clmul16_kara_seq.sv - self-checking bench for clmul16_kara_seq (MUL_LAT 0 and 2)

module tb_clmul16_kara_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, in_ready2, out_valid2;
  logic [30:0] out_y0, out_y2;
  logic [7:0]  mul_a0, mul_b0, mul_a2, mul_b2;
  logic [14:0] mul_y0, mul_y2, pipe_s1, pipe_s2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [14:0] core_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] r;
    r = 15'd0;
    for (int i = 0; i < 8; i++)
      if (a[i]) r = r ^ (15'(b) << i);
    return r;
  endfunction

  function automatic logic [30:0] ref_clmul(input logic [15:0] a, input logic [15:0] b);
    logic [30:0] r;
    r = 31'd0;
    for (int i = 0; i < 16; i++)
      if (a[i]) r = r ^ (31'(b) << i);
    return r;
  endfunction

  // External core models: combinational for MUL_LAT=0, two register stages for MUL_LAT=2.
  assign mul_y0 = core_mul8(mul_a0, mul_b0);
  always @(posedge clk) begin
    pipe_s1 <= core_mul8(mul_a2, mul_b2);
    pipe_s2 <= pipe_s1;
  end
  assign mul_y2 = pipe_s2;

  clmul16_kara_seq #(.MUL_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
    .out_y(out_y0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_y(mul_y0)
  );

  clmul16_kara_seq #(.MUL_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready),
    .out_y(out_y2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_y(mul_y2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {30'd0, in_ready0, in_ready2}, 32'h3);
    chk({tag, "_out_valid"}, {30'd0, out_valid0, out_valid2}, 32'h0);
    chk({tag, "_out_y0"}, {1'b0, out_y0}, 32'h0);
    chk({tag, "_out_y2"}, {1'b0, out_y2}, 32'h0);
    chk({tag, "_mul"}, {mul_a0, mul_b0, mul_a2, mul_b2}, 32'h0);
  endtask

  // One request through both DUTs; hold = extra cycles of out_ready=0 once both are valid.
  task automatic xact(input logic [15:0] a, input logic [15:0] b, input logic [30:0] exp, input int hold);
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    int lat0, lat2, k;
    ea[0] = a[7:0];  ea[1] = a[15:8] ^ a[7:0];  ea[2] = a[15:8];
    eb[0] = b[7:0];  eb[1] = b[15:8] ^ b[7:0];  eb[2] = b[15:8];

    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    chk("accept_ready", {30'd0, in_ready0, in_ready2}, 32'h3);
    @(posedge clk); #1;
    // Keep presenting junk: it must be ignored outside IDLE.
    in_a = 16'($urandom); in_b = 16'($urandom);
    lat0 = -1; lat2 = -1; k = 0;
    chk("mul0_pass", {16'd0, mul_a0, mul_b0}, {16'd0, ea[0], eb[0]});
    chk("mul2_pass", {16'd0, mul_a2, mul_b2}, {16'd0, ea[0], eb[0]});
    while (k < 40 && !(lat0 >= 0 && lat2 >= 0)) begin
      @(posedge clk); #1;
      k++;
      if (out_valid0 && lat0 < 0) lat0 = k;
      if (out_valid2 && lat2 < 0) lat2 = k;
      if (k < 3) chk("mul0_pass", {16'd0, mul_a0, mul_b0}, {16'd0, ea[k], eb[k]});
      if (k < 9) chk("mul2_pass", {16'd0, mul_a2, mul_b2}, {16'd0, ea[k/3], eb[k/3]});
      if (out_valid0) chk("y0_hold", {1'b0, out_y0}, {1'b0, exp});
    end
    chk("latency0", lat0, 3);
    chk("latency2", lat2, 9);
    chk("y2", {1'b0, out_y2}, {1'b0, exp});
    chk("resp_mul_zero", {mul_a0, mul_b0, mul_a2, mul_b2}, 32'h0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_valid", {30'd0, out_valid0, out_valid2}, 32'h3);
      chk("bp_ready", {30'd0, in_ready0, in_ready2}, 32'h0);
      chk("bp_y0", {1'b0, out_y0}, {1'b0, exp});
      chk("bp_y2", {1'b0, out_y2}, {1'b0, exp});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // in_valid was still high at the output handshake edge: it must not have been taken.
    chk("post_hs_valid", {30'd0, out_valid0, out_valid2}, 32'h0);
    chk("post_hs_ready", {30'd0, in_ready0, in_ready2}, 32'h3);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [30:0] y;
    int          hold;
  } vec_t;

  vec_t tbl [8];
  logic [15:0] ra, rb;
  int stray;

  initial begin
    tbl[0] = '{16'h0003, 16'h0003, 31'h00000005, 0};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 31'h55555555, 0};
    tbl[2] = '{16'h8000, 16'h8000, 31'h40000000, 1};
    tbl[3] = '{16'h00FF, 16'hFF00, 31'h00555500, 0};
    tbl[4] = '{16'h0100, 16'h0100, 31'h00010000, 2};
    tbl[5] = '{16'hFFFF, 16'h0001, 31'h0000FFFF, 0};
    tbl[6] = '{16'h0000, 16'h0000, 31'h00000000, 0};
    tbl[7] = '{16'hA5C3, 16'h0002, 31'h00014B86, 5};

    #3;
    chk_reset_outputs("rst0");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // out_ready while nothing is pending must do nothing.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk_reset_outputs("idle_or");

    for (int i = 0; i < 8; i++)
      xact(tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].hold);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      xact(ra, rb, ref_clmul(ra, rb), int'($urandom_range(0, 3)));
    end

    // Reset while DUT2 is in its middle pass (DUT0 is already holding a result).
    @(negedge clk);
    in_a = 16'hABCD; in_b = 16'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid2) stray++;
    end
    chk("no_stray_valid", stray, 0);
    xact(16'h1234, 16'h0001, 31'h00001234, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
